// File: rtl/minirv_lsu_pkg.sv
// Shared types and constants for the miniRV load/store unit.
package minirv_lsu_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    LSU_LW  = 2'b00,
    LSU_LBU = 2'b01,
    LSU_SW  = 2'b10,
    LSU_SB  = 2'b11
  } lsu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2,
    ST_DONE = 2'd3
  } lsu_state_e;

  localparam logic [3:0] WSTRB_WORD  = 4'hF;
  localparam logic [3:0] WSTRB_BYTE0 = 4'b0001;

  function automatic logic is_store(input lsu_op_e op);
    return op[1];
  endfunction

endpackage

// File: rtl/minirv_lsu_if.sv
// Data-memory bus between the LSU (master) and the memory (slave).
interface minirv_lsu_if;
  import minirv_lsu_pkg::*;

  logic            mem_valid;
  logic            mem_ready;
  logic            mem_we;
  logic [XLEN-1:0] mem_addr;
  logic [3:0]      mem_wstrb;
  logic [XLEN-1:0] mem_wdata;
  logic            mem_rvalid;
  logic [XLEN-1:0] mem_rdata;

  modport master (
    output mem_valid, mem_we, mem_addr, mem_wstrb, mem_wdata,
    input  mem_ready, mem_rvalid, mem_rdata
  );

  modport slave (
    input  mem_valid, mem_we, mem_addr, mem_wstrb, mem_wdata,
    output mem_ready, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/minirv_lsu_lane.sv
// Byte-lane steering: store strobe/data replication and load byte extract.
module minirv_lsu_lane
  import minirv_lsu_pkg::*;
(
  input  lsu_op_e         st_op_i,
  input  logic [1:0]      st_addr_lo_i,
  input  logic [XLEN-1:0] st_wdata_i,
  input  lsu_op_e         ld_op_i,
  input  logic [1:0]      ld_addr_lo_i,
  input  logic [XLEN-1:0] rdata_i,
  output logic [3:0]      wstrb_c_o,
  output logic [XLEN-1:0] wdata_c_o,
  output logic [XLEN-1:0] ld_data_c_o
);

  logic [7:0] ld_byte;

  always_comb begin
    wstrb_c_o = 4'b0000;
    wdata_c_o = '0;
    case (st_op_i)
      LSU_SW: begin
        wstrb_c_o = WSTRB_WORD;
        wdata_c_o = st_wdata_i;
      end
      LSU_SB: begin
        wstrb_c_o = WSTRB_BYTE0 << st_addr_lo_i;
        wdata_c_o = {4{st_wdata_i[7:0]}};
      end
      default: ;
    endcase
  end

  assign ld_byte     = rdata_i[{ld_addr_lo_i, 3'b000} +: 8];
  assign ld_data_c_o = (ld_op_i == LSU_LBU) ? XLEN'(ld_byte) : rdata_i;

endmodule

// File: rtl/minirv_lsu.sv
// miniRV load/store unit: one LW/LBU/SW/SB per request over a valid/ready + rvalid bus.
// Optional MINIRV_LSU_MISALIGN_TRAP_EN: misaligned LW/SW abort with err and no bus access.
module minirv_lsu
  import minirv_lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  input  logic [1:0]      req_op,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  input  logic [4:0]      req_rd,
  output logic            stall,
  output logic            wb_valid,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            err,
  minirv_lsu_if.master    mem
);

  localparam int unsigned     CNT_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

  lsu_state_e      state_q;
  logic [CNT_W-1:0] cnt_q;
  lsu_op_e         op_q;
  logic [1:0]      addr_lo_q;
  logic [4:0]      rd_q;
  logic            mem_valid_q, mem_we_q;
  logic [XLEN-1:0] mem_addr_q, mem_wdata_q;
  logic [3:0]      mem_wstrb_q;
  logic            wb_valid_q, err_q;
  logic [4:0]      wb_rd_q;
  logic [XLEN-1:0] wb_data_q;

  lsu_op_e         req_op_c;
  logic            trap_c, timeout_c;
  logic [3:0]      wstrb_c;
  logic [XLEN-1:0] wdata_c, ld_data_c;

  assign req_op_c = lsu_op_e'(req_op);

`ifdef MINIRV_LSU_MISALIGN_TRAP_EN
  assign trap_c = !req_op[0] && (req_addr[1:0] != 2'b00);
`else
  assign trap_c = 1'b0;
`endif

  // The access has used its last allowed REQ/RESP cycle.
  assign timeout_c = (cnt_q >= CNT_LAST);

  minirv_lsu_lane u_lane (
    .st_op_i      (req_op_c),
    .st_addr_lo_i (req_addr[1:0]),
    .st_wdata_i   (req_wdata),
    .ld_op_i      (op_q),
    .ld_addr_lo_i (addr_lo_q),
    .rdata_i      (mem.mem_rdata),
    .wstrb_c_o    (wstrb_c),
    .wdata_c_o    (wdata_c),
    .ld_data_c_o  (ld_data_c)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      op_q        <= LSU_LW;
      addr_lo_q   <= 2'b00;
      rd_q        <= 5'd0;
      mem_valid_q <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wstrb_q <= 4'b0000;
      mem_wdata_q <= '0;
      wb_valid_q  <= 1'b0;
      wb_rd_q     <= 5'd0;
      wb_data_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      wb_valid_q <= 1'b0;
      err_q      <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (req_valid) begin
            op_q      <= req_op_c;
            addr_lo_q <= req_addr[1:0];
            rd_q      <= req_rd;
            cnt_q     <= '0;
            if (trap_c) begin
              state_q <= ST_DONE;
              err_q   <= 1'b1;
            end else begin
              state_q     <= ST_REQ;
              mem_valid_q <= 1'b1;
              mem_we_q    <= is_store(req_op_c);
              mem_addr_q  <= {req_addr[XLEN-1:2], 2'b00};
              mem_wstrb_q <= wstrb_c;
              mem_wdata_q <= wdata_c;
            end
          end
        end
        ST_REQ: begin
          // Acceptance beats a timeout landing on the same cycle.
          if (mem.mem_ready) begin
            mem_valid_q <= 1'b0;
            cnt_q       <= cnt_q + CNT_W'(1);
            state_q     <= is_store(op_q) ? ST_DONE : ST_RESP;
          end else if (timeout_c) begin
            mem_valid_q <= 1'b0;
            state_q     <= ST_DONE;
            err_q       <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_RESP: begin
          if (mem.mem_rvalid) begin
            state_q    <= ST_DONE;
            wb_valid_q <= 1'b1;
            wb_rd_q    <= rd_q;
            wb_data_q  <= ld_data_c;
          end else if (timeout_c) begin
            state_q <= ST_DONE;
            err_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_DONE: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign stall = ((state_q == ST_IDLE) && req_valid) ||
                 (state_q == ST_REQ) || (state_q == ST_RESP);

  assign wb_valid      = wb_valid_q;
  assign wb_rd         = wb_rd_q;
  assign wb_data       = wb_data_q;
  assign err           = err_q;
  assign mem.mem_valid = mem_valid_q;
  assign mem.mem_we    = mem_we_q;
  assign mem.mem_addr  = mem_addr_q;
  assign mem.mem_wstrb = mem_wstrb_q;
  assign mem.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_minirv_lsu.sv
// Self-checking bench for minirv_lsu: directed scenarios plus randomized accesses vs. a cycle-count model.
module tb_minirv_lsu;
  import minirv_lsu_pkg::*;

  localparam int unsigned TO     = 16;
  localparam int          BUDGET = 24;
`ifdef MINIRV_LSU_MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  typedef struct {
    int          wb_cycle, wb_cnt, err_cycle, err_cnt, stall_rel, mv_cnt, acc_cycle;
    logic        stall0;
    logic [31:0] wb_data, acc_addr, acc_wdata;
    logic [4:0]  wb_rd;
    logic        acc_we;
    logic [3:0]  acc_wstrb;
  } obs_t;

  logic        clk, rst;
  logic        req_valid;
  logic [1:0]  req_op;
  logic [31:0] req_addr, req_wdata;
  logic [4:0]  req_rd;
  logic        stall, wb_valid, err;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  int          errors, checks;

  minirv_lsu_if mem_if ();

  minirv_lsu #(.TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_op(req_op), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_rd(req_rd), .stall(stall), .wb_valid(wb_valid),
    .wb_rd(wb_rd), .wb_data(wb_data), .err(err), .mem(mem_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected outcome from op, address and memory response timing (cycle 0 = request first seen).
  function automatic obs_t model(input logic [1:0] op, input logic [31:0] addr, wdata, rdata,
                                 input logic [4:0] rd, input int ready_dly, rvalid_dly);
    obs_t e;
    int a, r;
    e = '{wb_cycle: -1, wb_cnt: 0, err_cycle: -1, err_cnt: 0, stall_rel: -1, mv_cnt: 0,
          acc_cycle: -1, stall0: 1'b1, wb_data: 0, acc_addr: 0, acc_wdata: 0, wb_rd: 0,
          acc_we: 1'b0, acc_wstrb: 4'h0};
    if (TRAP_EN && (op == 2'b00 || op == 2'b10) && addr[1:0] != 2'b00) begin
      e.err_cycle = 1; e.err_cnt = 1; e.stall_rel = 1;
    end else if (ready_dly >= int'(TO)) begin
      e.err_cycle = TO + 1; e.err_cnt = 1; e.stall_rel = TO + 1; e.mv_cnt = TO;
    end else begin
      a = 1 + ready_dly;
      e.mv_cnt    = ready_dly + 1;
      e.acc_cycle = a;
      e.acc_addr  = addr - (addr % 4);
      e.acc_we    = op[1];
      if (op == 2'b10) begin
        e.acc_wstrb = 4'hF; e.acc_wdata = wdata;
      end else if (op == 2'b11) begin
        e.acc_wstrb = 4'(1 << addr[1:0]); e.acc_wdata = (wdata % 256) * 32'h0101_0101;
      end
      if (op[1]) begin
        e.stall_rel = a + 1;
      end else begin
        r = a + 1 + rvalid_dly;
        if (r <= int'(TO)) begin
          e.wb_cycle = r + 1; e.wb_cnt = 1; e.stall_rel = r + 1; e.wb_rd = rd;
          e.wb_data = (op == 2'b01) ? (rdata >> (8 * addr[1:0])) % 256 : rdata;
        end else begin
          e.err_cycle = TO + 1; e.err_cnt = 1; e.stall_rel = TO + 1;
        end
      end
    end
    return e;
  endfunction

  // Core + memory stimulus for one access; records what the DUT did, cycle by cycle.
  task automatic drive_access(input logic [1:0] op, input logic [31:0] addr, wdata, rdata,
                              input logic [4:0] rd, input int ready_dly, rvalid_dly,
                              output obs_t o);
    int req_seen;
    o = '{wb_cycle: -1, wb_cnt: 0, err_cycle: -1, err_cnt: 0, stall_rel: -1, mv_cnt: 0,
          acc_cycle: -1, stall0: 1'b0, wb_data: 0, acc_addr: 0, acc_wdata: 0, wb_rd: 0,
          acc_we: 1'b0, acc_wstrb: 4'h0};
    req_seen = 0;
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wdata; req_rd = rd;
    #1 o.stall0 = stall;
    for (int k = 1; k <= BUDGET; k++) begin
      @(negedge clk);
      mem_if.mem_ready = 1'b0; mem_if.mem_rvalid = 1'b0; mem_if.mem_rdata = 32'h0;
      if (wb_valid) begin
        if (o.wb_cycle < 0) begin o.wb_cycle = k; o.wb_data = wb_data; o.wb_rd = wb_rd; end
        o.wb_cnt++;
      end
      if (err) begin
        if (o.err_cycle < 0) o.err_cycle = k;
        o.err_cnt++;
      end
      if (!stall && o.stall_rel < 0) begin
        o.stall_rel = k;
        req_valid = 1'b0;
      end
      if (mem_if.mem_valid) begin
        o.mv_cnt++;
        if (req_seen == ready_dly && o.acc_cycle < 0) begin
          mem_if.mem_ready = 1'b1;
          o.acc_cycle = k; o.acc_addr = mem_if.mem_addr; o.acc_we = mem_if.mem_we;
          o.acc_wstrb = mem_if.mem_wstrb; o.acc_wdata = mem_if.mem_wdata;
        end
        req_seen++;
      end
      if (o.acc_cycle > 0 && k == o.acc_cycle + 1 + rvalid_dly) begin
        mem_if.mem_rvalid = 1'b1; mem_if.mem_rdata = rdata;
      end
    end
    req_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; req_valid = 1'b0; req_op = 2'b00; req_addr = 0; req_wdata = 0; req_rd = 0;
    mem_if.mem_ready = 1'b0; mem_if.mem_rvalid = 1'b0; mem_if.mem_rdata = 0;
    repeat (3) @(negedge clk);
    checks++;
    if ({stall, wb_valid, err, wb_rd, wb_data, mem_if.mem_valid, mem_if.mem_we, mem_if.mem_addr,
         mem_if.mem_wstrb, mem_if.mem_wdata} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got wb=%b err=%b mv=%b addr=%h exp all zero",
               wb_valid, err, mem_if.mem_valid, mem_if.mem_addr);
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_lw_basic();
    obs_t o;
    drive_access(2'b00, 32'h100, 32'h0, 32'hDEAD_BEEF, 5'd7, 0, 0, o);
    checks++; if (o.stall0 !== 1'b1) begin errors++; $display("FAIL lw_stall0 got %b exp 1", o.stall0); end
    checks++; if (o.wb_cycle !== 3) begin errors++; $display("FAIL lw_latency got %0d exp 3", o.wb_cycle); end
    checks++; if (o.wb_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL lw_data got %h exp deadbeef", o.wb_data); end
    checks++; if (o.wb_rd !== 5'd7) begin errors++; $display("FAIL lw_rd got %0d exp 7", o.wb_rd); end
    checks++; if (o.err_cnt !== 0 || o.wb_cnt !== 1) begin
      errors++; $display("FAIL lw_pulses got err=%0d wb=%0d exp 0/1", o.err_cnt, o.wb_cnt); end
  endtask

  task automatic test_lanes();
    obs_t o;
    drive_access(2'b01, 32'h103, 32'h0, 32'hAABB_CCDD, 5'd3, 0, 0, o);
    checks++; if (o.wb_data !== 32'h0000_00AA) begin errors++; $display("FAIL lbu_data got %h exp 000000aa", o.wb_data); end
    drive_access(2'b11, 32'h102, 32'h1234_5678, 32'h0, 5'd0, 0, 0, o);
    checks++; if (o.acc_wstrb !== 4'b0100) begin errors++; $display("FAIL sb_wstrb got %b exp 0100", o.acc_wstrb); end
    checks++; if (o.acc_wdata !== 32'h7878_7878) begin errors++; $display("FAIL sb_wdata got %h exp 78787878", o.acc_wdata); end
    checks++; if (o.acc_addr !== 32'h100 || o.acc_we !== 1'b1) begin
      errors++; $display("FAIL sb_addr got %h we=%b exp 00000100 we=1", o.acc_addr, o.acc_we); end
    checks++; if (o.stall_rel !== 2) begin errors++; $display("FAIL sb_done got %0d exp 2", o.stall_rel); end
  endtask

  task automatic test_store_wait();
    obs_t o;
    drive_access(2'b10, 32'h40, 32'hCAFE_0001, 32'h0, 5'd0, 5, 0, o);
    checks++; if (o.mv_cnt !== 6) begin errors++; $display("FAIL sw_wait_valid got %0d exp 6", o.mv_cnt); end
    checks++; if (o.stall_rel !== 7) begin errors++; $display("FAIL sw_wait_done got %0d exp 7", o.stall_rel); end
    checks++; if (o.wb_cnt !== 0 || o.err_cnt !== 0) begin
      errors++; $display("FAIL sw_wait_pulses got wb=%0d err=%0d exp 0/0", o.wb_cnt, o.err_cnt); end
  endtask

  task automatic test_timeout();
    obs_t o;
    drive_access(2'b00, 32'h80, 32'h0, 32'h1111_2222, 5'd4, 0, 1000, o);
    checks++; if (o.err_cycle !== TO + 1 || o.err_cnt !== 1) begin
      errors++; $display("FAIL to_err got cyc=%0d cnt=%0d exp %0d/1", o.err_cycle, o.err_cnt, TO + 1); end
    checks++; if (o.wb_cnt !== 0 || o.stall_rel !== TO + 1) begin
      errors++; $display("FAIL to_release got wb=%0d rel=%0d exp 0/%0d", o.wb_cnt, o.stall_rel, TO + 1); end
    drive_access(2'b00, 32'h84, 32'h0, 32'h3333_4444, 5'd5, 0, TO - 2, o);
    checks++; if (o.wb_cycle !== TO + 1 || o.err_cnt !== 0) begin
      errors++; $display("FAIL to_rvalid_wins got wb=%0d err=%0d exp %0d/0", o.wb_cycle, o.err_cnt, TO + 1); end
    checks++; if (o.wb_data !== 32'h3333_4444) begin errors++; $display("FAIL to_rvalid_data got %h exp 33334444", o.wb_data); end
    drive_access(2'b10, 32'h88, 32'h5, 32'h0, 5'd0, 30, 0, o);
    checks++; if (o.mv_cnt !== TO || o.err_cycle !== TO + 1) begin
      errors++; $display("FAIL to_req got mv=%0d err=%0d exp %0d/%0d", o.mv_cnt, o.err_cycle, TO, TO + 1); end
  endtask

  task automatic test_reset_midflight();
    obs_t o;
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'b00; req_addr = 32'h200; req_rd = 5'd9;
    @(negedge clk);
    mem_if.mem_ready = mem_if.mem_valid;
    @(negedge clk);
    mem_if.mem_ready = 1'b0;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL rstmid_pre_stall got %b exp 1", stall); end
    rst = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({stall, wb_valid, err, wb_rd, wb_data, mem_if.mem_valid, mem_if.mem_we, mem_if.mem_addr,
         mem_if.mem_wstrb, mem_if.mem_wdata} !== '0) begin
      errors++; $display("FAIL rstmid_outputs got stall=%b mv=%b addr=%h exp all zero",
                         stall, mem_if.mem_valid, mem_if.mem_addr);
    end
    rst = 1'b1; mem_if.mem_rvalid = 1'b1; mem_if.mem_rdata = $urandom;
    @(negedge clk);
    mem_if.mem_rvalid = 1'b0;
    checks++; if (wb_valid !== 1'b0 || stall !== 1'b0 || mem_if.mem_valid !== 1'b0) begin
      errors++; $display("FAIL rstmid_stray got wb=%b stall=%b mv=%b exp 0/0/0", wb_valid, stall, mem_if.mem_valid); end
    drive_access(2'b00, 32'h204, 32'h0, 32'h0BAD_F00D, 5'd10, 0, 0, o);
    checks++; if (o.wb_cycle !== 3 || o.wb_data !== 32'h0BAD_F00D) begin
      errors++; $display("FAIL rstmid_after got cyc=%0d data=%h exp 3/0badf00d", o.wb_cycle, o.wb_data); end
  endtask

  task automatic test_misalign();
    obs_t o, e;
    drive_access(2'b00, 32'h101, 32'h0, 32'hCAFE_F00D, 5'd12, 0, 0, o);
    e = model(2'b00, 32'h101, 32'h0, 32'hCAFE_F00D, 5'd12, 0, 0);
    checks++; if (o.err_cycle !== e.err_cycle || o.wb_cycle !== e.wb_cycle) begin
      errors++; $display("FAIL misalign_timing got err=%0d wb=%0d exp %0d/%0d", o.err_cycle, o.wb_cycle, e.err_cycle, e.wb_cycle); end
    checks++; if (o.mv_cnt !== e.mv_cnt || o.acc_addr !== e.acc_addr || o.wb_data !== e.wb_data) begin
      errors++; $display("FAIL misalign_access got mv=%0d addr=%h data=%h exp %0d/%h/%h",
                         o.mv_cnt, o.acc_addr, o.wb_data, e.mv_cnt, e.acc_addr, e.wb_data); end
  endtask

  task automatic test_random();
    obs_t o, e;
    logic [1:0] op;
    logic [31:0] addr, wdata, rdata;
    logic [4:0] rd;
    int rdy, rv;
    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom); addr = $urandom; wdata = $urandom; rdata = $urandom;
      rd = 5'($urandom_range(1, 31));
      rdy = ($urandom_range(0, 9) == 0) ? 20 : int'($urandom_range(0, 4));
      rv  = ($urandom_range(0, 7) == 0) ? 1000 : int'($urandom_range(0, 4));
      drive_access(op, addr, wdata, rdata, rd, rdy, rv, o);
      e = model(op, addr, wdata, rdata, rd, rdy, rv);
      checks++; if (o.wb_cycle !== e.wb_cycle || o.wb_cnt !== e.wb_cnt) begin
        errors++; $display("FAIL rnd%0d_wb got %0d/%0d exp %0d/%0d", i, o.wb_cycle, o.wb_cnt, e.wb_cycle, e.wb_cnt); end
      checks++; if (o.wb_data !== e.wb_data || o.wb_rd !== e.wb_rd) begin
        errors++; $display("FAIL rnd%0d_wbdata got %h rd%0d exp %h rd%0d", i, o.wb_data, o.wb_rd, e.wb_data, e.wb_rd); end
      checks++; if (o.err_cycle !== e.err_cycle || o.err_cnt !== e.err_cnt) begin
        errors++; $display("FAIL rnd%0d_err got %0d/%0d exp %0d/%0d", i, o.err_cycle, o.err_cnt, e.err_cycle, e.err_cnt); end
      checks++; if (o.stall_rel !== e.stall_rel || o.stall0 !== e.stall0 || o.mv_cnt !== e.mv_cnt) begin
        errors++; $display("FAIL rnd%0d_stall got rel=%0d s0=%b mv=%0d exp %0d/%b/%0d",
                           i, o.stall_rel, o.stall0, o.mv_cnt, e.stall_rel, e.stall0, e.mv_cnt); end
      checks++; if (o.acc_cycle !== e.acc_cycle || o.acc_addr !== e.acc_addr || o.acc_we !== e.acc_we ||
                    o.acc_wstrb !== e.acc_wstrb) begin
        errors++; $display("FAIL rnd%0d_bus got c=%0d a=%h we=%b s=%b exp c=%0d a=%h we=%b s=%b", i,
                           o.acc_cycle, o.acc_addr, o.acc_we, o.acc_wstrb, e.acc_cycle, e.acc_addr, e.acc_we, e.acc_wstrb); end
      if (op[1]) begin
        checks++; if (o.acc_wdata !== e.acc_wdata) begin
          errors++; $display("FAIL rnd%0d_wdata got %h exp %h", i, o.acc_wdata, e.acc_wdata); end
      end
    end
  endtask

  initial begin
    errors = 0; checks = 0;
    test_reset();
    test_lw_basic();
    test_lanes();
    test_store_wait();
    test_timeout();
    test_reset_midflight();
    test_misalign();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
